// File: rtl/button_event.sv
// button_event: turns a debounced button level into press, release,
// long-press and auto-repeat strobes, plus a "held" level.
// Optional feature: define BUTTON_EVENT_REPEAT_EN to enable auto-repeat
// strobes while a long press is held. Without it repeat_pulse is tied low.
// All outputs come straight from flops; button_in only reaches them
// through the next-state logic.
module button_event #(
    parameter int LONG_TIME   = 50_000_000,
    parameter int REPEAT_TIME = 10_000_000,
    parameter int CNT_W       = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic button_in,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse,
    output logic repeat_pulse,
    output logic held
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PRESSED = 2'd1;
    localparam logic [1:0] LONG    = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_TIME - 1);

    // Reject configurations where a threshold would not fit the counter.
    if ((LONG_TIME < 2) || ((LONG_TIME >> CNT_W) != 0)) begin : g_bad_long
        $error("button_event: LONG_TIME out of range for CNT_W");
    end
    if ((REPEAT_TIME < 2) || ((REPEAT_TIME >> CNT_W) != 0)) begin : g_bad_repeat
        $error("button_event: REPEAT_TIME out of range for CNT_W");
    end

    logic [1:0]       state_r;
    logic [1:0]       state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             press_s;
    logic             release_s;
    logic             long_s;
    logic             held_s;

`ifdef BUTTON_EVENT_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_MAX = CNT_W'(REPEAT_TIME - 1);
    logic repeat_s;
    logic repeat_r;
`endif

    // Next-state, counter and strobe decode; release always wins over thresholds.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        press_s   = 1'b0;
        release_s = 1'b0;
        long_s    = 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
        repeat_s  = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (button_in) begin
                    state_s = PRESSED;
                    cnt_s   = CNT_ZERO;
                    press_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            PRESSED: begin
                if (!button_in) begin
                    state_s   = IDLE;
                    cnt_s     = CNT_ZERO;
                    release_s = 1'b1;
                end else if (cnt_r == LONG_MAX) begin
                    state_s = LONG;
                    cnt_s   = CNT_ZERO;
                    long_s  = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            LONG: begin
                if (!button_in) begin
                    state_s   = IDLE;
                    cnt_s     = CNT_ZERO;
                    release_s = 1'b1;
                end else begin
`ifdef BUTTON_EVENT_REPEAT_EN
                    if (cnt_r == REP_MAX) begin
                        cnt_s    = CNT_ZERO;
                        repeat_s = 1'b1;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
`else
                    cnt_s = CNT_ZERO;
`endif
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
        held_s = (state_s != IDLE);
    end

    // State, counter and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r          <= IDLE;
            cnt_r            <= CNT_ZERO;
            press_pulse      <= 1'b0;
            release_pulse    <= 1'b0;
            long_press_pulse <= 1'b0;
            held             <= 1'b0;
        end else begin
            state_r          <= state_s;
            cnt_r            <= cnt_s;
            press_pulse      <= press_s;
            release_pulse    <= release_s;
            long_press_pulse <= long_s;
            held             <= held_s;
        end
    end

`ifdef BUTTON_EVENT_REPEAT_EN
    // Auto-repeat strobe register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            repeat_r <= 1'b0;
        end else begin
            repeat_r <= repeat_s;
        end
    end
    assign repeat_pulse = repeat_r;
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule
